// File: rtl/pcpu_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : pcpu_mdu
//  Description : Iterative multiply/divide unit for the PCPU EX stage.
//                Radix-2 shift-add multiply and restoring divide on operand
//                magnitudes, sign fix-up in a final cycle, owns HI/LO.
//  Revision    : 1.0  initial release
// ============================================================================
module pcpu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW          = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] c_last_step = CW'(WIDTH - 1);

    localparam logic [2:0] c_op_mult  = 3'd0;
    localparam logic [2:0] c_op_multu = 3'd1;
    localparam logic [2:0] c_op_div   = 3'd2;
    localparam logic [2:0] c_op_divu  = 3'd3;
    localparam logic [2:0] c_op_mthi  = 3'd4;
    localparam logic [2:0] c_op_mtlo  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_count;

    // r_acc: product high half / partial remainder
    // r_shf: multiplier shifting out, product low half / dividend shifting out, quotient
    // r_opnd: multiplicand / divisor magnitude
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_shf;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_a_orig;
    logic             r_is_div;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic             r_b_zero;

    logic             w_signed_op;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // Operand decode, magnitudes, one datapath step and the final sign fix-up
    always_comb begin
        w_signed_op = (op == c_op_mult) || (op == c_op_div);
        w_a_neg     = w_signed_op & a[WIDTH-1];
        w_b_neg     = w_signed_op & b[WIDTH-1];
        w_a_mag     = w_a_neg ? (~a + 1'b1) : a;
        w_b_mag     = w_b_neg ? (~b + 1'b1) : b;

        // Multiply step: conditionally add the multiplicand into the high half
        w_sum       = {1'b0, r_acc} + {1'b0, (r_shf[0] ? r_opnd : {WIDTH{1'b0}})};
        // Divide step: trial subtract of divisor from remainder shifted left by one
        w_trial     = {r_acc, r_shf[WIDTH-1]} - {1'b0, r_opnd};

        w_prod      = {r_acc, r_shf};
        w_prod_fix  = r_neg_res ? (~w_prod + 1'b1) : w_prod;
        w_quot_fix  = r_neg_res ? (~r_shf + 1'b1) : r_shf;
        w_rem_fix   = r_neg_rem ? (~r_acc + 1'b1) : r_acc;
    end

    // Control FSM plus datapath and HI/LO registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_count   <= '0;
            r_acc     <= '0;
            r_shf     <= '0;
            r_opnd    <= '0;
            r_a_orig  <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b_zero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                // Kill wins over everything, including a start or a pending write-back
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            case (op)
                                c_op_mult, c_op_multu: begin
                                    r_acc     <= '0;
                                    r_shf     <= w_b_mag;
                                    r_opnd    <= w_a_mag;
                                    r_is_div  <= 1'b0;
                                    r_neg_res <= w_a_neg ^ w_b_neg;
                                    r_neg_rem <= 1'b0;
                                    r_b_zero  <= (b == '0);
                                    r_a_orig  <= a;
                                    r_count   <= '0;
                                    r_busy    <= 1'b1;
                                    r_state   <= S_CALC;
                                end
                                c_op_div, c_op_divu: begin
                                    r_acc     <= '0;
                                    r_shf     <= w_a_mag;
                                    r_opnd    <= w_b_mag;
                                    r_is_div  <= 1'b1;
                                    r_neg_res <= w_a_neg ^ w_b_neg;
                                    r_neg_rem <= w_a_neg;
                                    r_b_zero  <= (b == '0);
                                    r_a_orig  <= a;
                                    r_count   <= '0;
                                    r_busy    <= 1'b1;
                                    r_state   <= S_CALC;
                                end
                                c_op_mthi: r_hi <= a;
                                c_op_mtlo: r_lo <= a;
                                default: ;
                            endcase
                        end
                    end
                    S_CALC: begin
                        if (r_is_div) begin
                            if (!w_trial[WIDTH]) begin
                                r_acc <= w_trial[WIDTH-1:0];
                                r_shf <= {r_shf[WIDTH-2:0], 1'b1};
                            end else begin
                                r_acc <= {r_acc[WIDTH-2:0], r_shf[WIDTH-1]};
                                r_shf <= {r_shf[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            r_acc <= w_sum[WIDTH:1];
                            r_shf <= {w_sum[0], r_shf[WIDTH-1:1]};
                        end
                        r_count <= r_count + CW'(1);
                        if (r_count == c_last_step) begin
                            r_state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        if (!r_is_div) begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end else if (r_b_zero) begin
                            // Divide by zero returns all-ones quotient and the raw dividend
                            r_hi <= r_a_orig;
                            r_lo <= {WIDTH{1'b1}};
                        end else begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire
